// File: rtl/debounce_pkg.sv
// Shared constants, arbiter state encoding and a ceiling-log2 helper
// for the button debounce and event scheduling block.
package debounce_pkg;

    localparam int DEF_TICK_DIV       = 50000;
    localparam int DEF_STABLE_SAMPLES = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: 2-FF synchroniser, sampled history and debounced level.
// Latency: 2 clk sync + STABLE_SAMPLES ticks; rise is combinational with the level update.
// Backpressure: none, free-running on the shared tick.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    output logic level,
    output logic rise
);

    logic                      r_sync1;
    logic                      r_sync2;
    logic [STABLE_SAMPLES-1:0] r_hist;
    logic                      r_level;
    logic [STABLE_SAMPLES-1:0] w_hist_next;
    logic                      w_all1;
    logic                      w_all0;

    assign w_hist_next = {r_hist[STABLE_SAMPLES-2:0], r_sync2};
    assign w_all1      = &w_hist_next;
    assign w_all0      = ~|w_hist_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (tick) begin
                r_hist <= w_hist_next;
                if (w_all1) begin
                    r_level <= 1'b1;
                end else if (w_all0) begin
                    r_level <= 1'b0;
                end
            end
        end
    end

    // Only the 0->1 transition is reported; releases are silent.
    assign rise  = tick & w_all1 & ~r_level;
    assign level = r_level;

endmodule

// File: rtl/button_event_scheduler.sv
// Debounces N_BTN buttons and serves their press events round-robin on a valid/ready port.
// Latency: rise -> pending 1 clk, pending -> evt_valid 1 clk; at most one event per 2 clk.
// Backpressure: evt_valid/evt_id hold until evt_ready; a repeat press while pending pulses evt_overrun.
module button_event_scheduler
    import debounce_pkg::*;
#(
    parameter int N_BTN          = 4,
    parameter int TICK_DIV       = DEF_TICK_DIV,
    parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter int IDW            = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    output logic [IDW-1:0]   evt_id,
    input  logic             evt_ready,
    output logic             evt_overrun
);

    localparam int CNT_W = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] r_pending;
    logic [N_BTN-1:0] w_pending_next;
    logic [N_BTN-1:0] w_ack_vec;
    logic             w_ack;
    logic             w_overrun;
    logic             r_overrun;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_evt_id;
    logic [IDW-1:0]   w_pick;
    logic             w_found;
    int               w_idx;
    arb_state_t       r_state;
    arb_state_t       w_state_next;

    assign w_tick = (r_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        debounce_channel #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_in[g]),
            .tick (w_tick),
            .level(btn_level[g]),
            .rise (w_rise[g])
        );
    end

    assign w_ack = (r_state == PRESENT) && evt_ready;

    always_comb begin
        w_ack_vec = '0;
        if (w_ack) begin
            w_ack_vec[r_evt_id] = 1'b1;
        end
    end

    // A rise landing on the ack of the same id re-arms pending instead of being lost.
    assign w_pending_next = w_rise | (r_pending & ~w_ack_vec);
    assign w_overrun      = |(w_rise & r_pending & ~w_ack_vec);

    // First pending bit at or above rr_ptr, wrapping without a modulo so odd N_BTN works.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = 0; k < N_BTN; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= N_BTN) begin
                w_idx = w_idx - N_BTN;
            end
            if (!w_found && r_pending[w_idx]) begin
                w_found = 1'b1;
                w_pick  = IDW'(w_idx);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_found)   w_state_next = PRESENT;
            PRESENT: if (evt_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_overrun <= 1'b0;
            r_evt_id  <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            r_overrun <= w_overrun;
            if (r_state == IDLE && w_found) begin
                r_evt_id <= w_pick;
            end
            if (w_ack) begin
                r_rr_ptr <= (r_evt_id == IDW'(N_BTN - 1)) ? '0 : r_evt_id + 1'b1;
            end
        end
    end

    assign evt_valid   = (r_state == PRESENT);
    assign evt_id      = r_evt_id;
    assign evt_overrun = r_overrun;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler with TICK_DIV=4, STABLE_SAMPLES=4.
module tb_button_event_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_ready;
    logic       evt_overrun;

    int n_vec;
    int n_err;
    int n_evt;
    int n_ovr;
    int ncyc;
    int cyc;
    logic [1:0] id_log [0:63];
    int         hs_cyc [0:63];

    button_event_scheduler #(
        .N_BTN(4), .TICK_DIV(4), .STABLE_SAMPLES(4), .IDW(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .evt_valid  (evt_valid),
        .evt_id     (evt_id),
        .evt_ready  (evt_ready),
        .evt_overrun(evt_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since the last reset edge; lines up with the debounce tick phase.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Handshakes and overrun pulses sampled mid-cycle.
    initial begin
        n_evt = 0;
        n_ovr = 0;
        ncyc  = 0;
    end
    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (!rst && evt_valid && evt_ready && n_evt < 64) begin
            id_log[n_evt] <= evt_id;
            hs_cyc[n_evt] <= ncyc;
            n_evt         <= n_evt + 1;
        end
        if (!rst && evt_overrun) n_ovr <= n_ovr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int  e0;
    int  o0;
    int  lat;
    logic ok;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        btn_in    = 4'b0000;
        evt_ready = 1'b0;
        step(3);
        chk("rst_valid",   32'(evt_valid),   32'd0);
        chk("rst_id",      32'(evt_id),      32'd0);
        chk("rst_overrun", 32'(evt_overrun), 32'd0);
        chk("rst_level",   32'(btn_level),   32'd0);
        rst = 1'b0;
        step(2);

        // Bounce on button 0: period-6 square wave never yields 4 equal samples.
        evt_ready = 1'b1;
        e0 = n_evt;
        for (int k = 0; k < 13; k++) begin
            btn_in[0] = ~btn_in[0];
            step(3);
        end
        chk("bounce_noevt", 32'(n_evt - e0), 32'd0);
        chk("bounce_lvl0",  32'(btn_level[0]), 32'd0);
        btn_in[0] = 1'b1;
        lat = 99;
        for (int k = 1; k <= 25; k++) begin
            step(1);
            if (btn_level[0]) begin
                lat = k;
                break;
            end
        end
        chk("bounce_lat_le19", 32'(lat <= 19), 32'd1);
        step(5);
        chk("bounce_one_evt", 32'(n_evt - e0), 32'd1);
        chk("bounce_id",      32'(id_log[e0]), 32'd0);
        btn_in[0] = 1'b0;
        step(30);

        // Simultaneous 1 and 3 (rr_ptr=1), then 0 and 3 (rr_ptr=0).
        e0 = n_evt;
        btn_in = 4'b1010;
        step(30);
        chk("sim13_cnt", 32'(n_evt - e0), 32'd2);
        chk("sim13_id0", 32'(id_log[e0]), 32'd1);
        chk("sim13_id1", 32'(id_log[e0+1]), 32'd3);
        chk("sim13_gap", 32'(hs_cyc[e0+1] - hs_cyc[e0]), 32'd2);
        btn_in = 4'b0000;
        step(30);
        e0 = n_evt;
        btn_in = 4'b1001;
        step(30);
        chk("sim03_cnt", 32'(n_evt - e0), 32'd2);
        chk("sim03_id0", 32'(id_log[e0]), 32'd0);
        chk("sim03_id1", 32'(id_log[e0+1]), 32'd3);
        btn_in = 4'b0000;
        step(30);

        // Backpressure on button 2, then a repeat press while still pending.
        evt_ready = 1'b0;
        btn_in[2] = 1'b1;
        step(30);
        chk("bp_valid", 32'(evt_valid), 32'd1);
        chk("bp_id",    32'(evt_id),    32'd2);
        ok = 1'b1;
        for (int k = 0; k < 200; k++) begin
            step(1);
            if (!(evt_valid && evt_id == 2'd2)) ok = 1'b0;
        end
        chk("bp_hold200", 32'(ok), 32'd1);
        o0 = n_ovr;
        btn_in[2] = 1'b0;
        step(30);
        btn_in[2] = 1'b1;
        step(30);
        chk("bp_overrun_1clk", 32'(n_ovr - o0), 32'd1);
        e0 = n_evt;
        evt_ready = 1'b1;
        step(10);
        chk("bp_drain_cnt", 32'(n_evt - e0), 32'd1);
        chk("bp_drain_id",  32'(id_log[e0]), 32'd2);
        chk("bp_empty",     32'(evt_valid),  32'd0);
        btn_in[2] = 1'b0;
        step(30);

        // Reset while an event for button 1 is presented.
        evt_ready = 1'b0;
        btn_in[1] = 1'b1;
        step(30);
        chk("rmid_valid", 32'(evt_valid), 32'd1);
        chk("rmid_id",    32'(evt_id),    32'd1);
        rst    = 1'b1;
        btn_in = 4'b0000;
        step(1);
        rst = 1'b0;
        chk("rmid_valid0", 32'(evt_valid), 32'd0);
        chk("rmid_level0", 32'(btn_level), 32'd0);
        evt_ready = 1'b1;
        e0 = n_evt;
        step(40);
        chk("rmid_noevt", 32'(n_evt - e0), 32'd0);

        // Release of an already-acked button produces nothing.
        e0 = n_evt;
        o0 = n_ovr;
        btn_in[3] = 1'b1;
        step(30);
        chk("rel_evt",  32'(n_evt - e0), 32'd1);
        chk("rel_id",   32'(id_log[e0]), 32'd3);
        btn_in[3] = 1'b0;
        step(8);
        chk("rel_lvl_hold", 32'(btn_level[3]), 32'd1);
        step(30);
        chk("rel_lvl_fall", 32'(btn_level[3]), 32'd0);
        chk("rel_noevt",    32'(n_evt - e0), 32'd1);
        chk("rel_noovr",    32'(n_ovr - o0), 32'd0);

        // Set-wins: re-press of button 0 debounces on the same edge as its ack.
        evt_ready = 1'b0;
        btn_in[0] = 1'b1;
        step(30);
        chk("sw_valid", 32'(evt_valid), 32'd1);
        chk("sw_id",    32'(evt_id),    32'd0);
        btn_in[0] = 1'b0;
        step(30);
        chk("sw_released", 32'(btn_level[0]), 32'd0);
        for (int k = 0; k < 8; k++) begin
            step(1);
            if (cyc % 4 == 0) break;
        end
        e0 = n_evt;
        o0 = n_ovr;
        btn_in[0] = 1'b1;
        step(15);
        chk("sw_pre_rise", 32'(btn_level[0]), 32'd0);
        evt_ready = 1'b1;
        step(1);
        chk("sw_rise_edge", 32'(btn_level[0]), 32'd1);
        step(10);
        chk("sw_cnt",   32'(n_evt - e0),   32'd2);
        chk("sw_id0",   32'(id_log[e0]),   32'd0);
        chk("sw_id1",   32'(id_log[e0+1]), 32'd0);
        chk("sw_noovr", 32'(n_ovr - o0),   32'd0);
        chk("sw_idle",  32'(evt_valid),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
